// File: rtl/adc_spi_resp_pkg.sv
// Shared constants, frame layout and FSM encoding for the ADC-side SPI responder.
package adc_spi_resp_pkg;

  localparam int unsigned FRAME_BITS  = 24;
  localparam int unsigned ADDR_BITS   = 7;
  localparam int unsigned DATA_BITS   = 16;
  localparam int unsigned RNW_BIT     = 23;
  localparam int unsigned CNT_BITS    = 5;
  localparam int unsigned RD_LOAD_BIT = 8;
  localparam logic [ADDR_BITS-1:0] ERRCNT_CLR_ADDR = 7'h7F;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT,
    WAIT_HI
  } state_e;

  typedef struct packed {
    logic                 rnw;
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_BITS-1:0] data;
  } frame_t;

endpackage

// File: rtl/adc_spi_responder_pin_sync.sv
// spi_pin_sync: multi-flop synchronizer for one SPI pin plus an edge-detect flop
// producing single-cycle rise/fall pulses on the synchronized level.
module spi_pin_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise_c,
  output logic fall_c
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Reset to 0 so a csn that is high at reset release is seen as a fresh high level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q      = sync_q[SYNC_STAGES-1];
  assign rise_c = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_c = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/adc_spi_responder.sv
// ADC stand-in SPI slave: 24-bit read/write frames into a 16-bit register bank,
// all pins oversampled in init_clk. Optional abort counter: ADC_SPI_RESP_ERRCNT_EN.
module adc_spi_responder
  import adc_spi_resp_pkg::*;
#(
  parameter int unsigned             NUM_REGS     = 16,
  parameter logic [NUM_REGS*16-1:0]  RESET_VALUES = '0,
  parameter int unsigned             SYNC_STAGES  = 2
) (
  input  logic                      init_clk,
  input  logic                      init_rst,
  input  logic                      adc_spi_csn,
  input  logic                      adc_spi_sclk,
  input  logic                      adc_spi_mosi,
  output logic                      adc_spi_miso,
  output logic                      adc_spi_miso_oe,
  output logic                      reg_wr_valid,
  output logic [6:0]                reg_wr_addr,
  output logic [15:0]               reg_wr_data,
  output logic [NUM_REGS*16-1:0]    reg_bank
`ifdef ADC_SPI_RESP_ERRCNT_EN
  ,
  output logic [15:0]               frame_err_cnt
`endif
);

  logic csn_s, csn_rise_c, csn_fall_c;
  logic sclk_rise_c, sclk_fall_c;
  logic mosi_s;
  logic sclk_level_unused;
  logic [1:0] mosi_edges_unused;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_csn (
    .clk(init_clk), .rst(init_rst), .d(adc_spi_csn),
    .q(csn_s), .rise_c(csn_rise_c), .fall_c(csn_fall_c)
  );

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(init_clk), .rst(init_rst), .d(adc_spi_sclk),
    .q(sclk_level_unused), .rise_c(sclk_rise_c), .fall_c(sclk_fall_c)
  );

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(init_clk), .rst(init_rst), .d(adc_spi_mosi),
    .q(mosi_s), .rise_c(mosi_edges_unused[0]), .fall_c(mosi_edges_unused[1])
  );

  state_e                state_q, state_d;
  logic [CNT_BITS-1:0]   bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0] shift_in_q, shift_in_d;
  logic [DATA_BITS-1:0]  shift_out_q, shift_out_d;
  logic                  miso_q, miso_d;
  logic                  miso_oe_q, miso_oe_d;
  logic                  reg_wr_valid_q, reg_wr_valid_d;
  logic [ADDR_BITS-1:0]  reg_wr_addr_q, reg_wr_addr_d;
  logic [DATA_BITS-1:0]  reg_wr_data_q, reg_wr_data_d;
  logic                  soft_rst_q, soft_rst_d;
  logic [DATA_BITS-1:0]  bank_q [NUM_REGS];
  logic [DATA_BITS-1:0]  bank_d [NUM_REGS];
`ifdef ADC_SPI_RESP_ERRCNT_EN
  logic [15:0]           err_cnt_q, err_cnt_d;
`endif

  frame_t                frame_c;
  logic [ADDR_BITS-1:0]  rd_addr_c;
  logic [DATA_BITS-1:0]  rd_word_c;
  logic                  wr_hit_c;

  assign frame_c = shift_in_q;
  // Address as it stands once the 8th bit is shifted in this cycle.
  assign rd_addr_c = {shift_in_q[ADDR_BITS-2:0], mosi_s};

  // Out-of-range addresses match no register and read back as zero.
  always_comb begin
    rd_word_c = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (rd_addr_c == ADDR_BITS'(k)) rd_word_c = bank_q[k];
    end
  end

  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    shift_in_d     = shift_in_q;
    shift_out_d    = shift_out_q;
    miso_oe_d      = miso_oe_q;
    reg_wr_valid_d = 1'b0;
    reg_wr_addr_d  = reg_wr_addr_q;
    reg_wr_data_d  = reg_wr_data_q;
    soft_rst_d     = 1'b0;
    bank_d         = bank_q;
    wr_hit_c       = 1'b0;
`ifdef ADC_SPI_RESP_ERRCNT_EN
    err_cnt_d      = err_cnt_q;
`endif

    unique case (state_q)
      WAIT_HI: begin
        if (csn_s) state_d = IDLE;
      end
      IDLE: begin
        if (csn_fall_c) begin
          state_d    = SHIFT;
          bit_cnt_d  = '0;
          shift_in_d = '0;
        end
      end
      SHIFT: begin
        // csn rise takes priority over any coincident sclk edge.
        if (csn_rise_c) begin
          miso_oe_d = 1'b0;
          if (bit_cnt_q == CNT_BITS'(FRAME_BITS)) begin
            state_d = COMMIT;
            if (!shift_in_q[RNW_BIT]) begin
              for (int k = 0; k < NUM_REGS; k++) begin
                if (frame_c.addr == ADDR_BITS'(k)) begin
                  bank_d[k] = frame_c.data;
                  wr_hit_c  = 1'b1;
                end
              end
              if (wr_hit_c) begin
                reg_wr_valid_d = 1'b1;
                reg_wr_addr_d  = frame_c.addr;
                reg_wr_data_d  = frame_c.data;
              end
              soft_rst_d = (frame_c.addr == '0) && frame_c.data[0];
`ifdef ADC_SPI_RESP_ERRCNT_EN
              if (frame_c.addr == ERRCNT_CLR_ADDR) err_cnt_d = '0;
`endif
            end
          end else begin
            state_d = IDLE;
`ifdef ADC_SPI_RESP_ERRCNT_EN
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 16'd1;
`endif
          end
        end else if (sclk_rise_c) begin
          shift_in_d = {shift_in_q[FRAME_BITS-2:0], mosi_s};
          if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + CNT_BITS'(1);
          if ((bit_cnt_q == CNT_BITS'(RD_LOAD_BIT - 1)) && shift_in_d[RD_LOAD_BIT-1]) begin
            shift_out_d = rd_word_c;
            miso_oe_d   = 1'b1;
          end
        end else if (sclk_fall_c && miso_oe_q && (bit_cnt_q > CNT_BITS'(RD_LOAD_BIT))) begin
          // The fall right after the load keeps bit 15 up for the 9th rise.
          shift_out_d = {shift_out_q[DATA_BITS-2:0], 1'b0};
        end
      end
      COMMIT: begin
        state_d = IDLE;
        if (soft_rst_q) begin
          for (int k = 0; k < NUM_REGS; k++) begin
            bank_d[k] = RESET_VALUES[k*DATA_BITS +: DATA_BITS];
          end
          bank_d[0][0] = 1'b0;
        end
      end
      default: state_d = WAIT_HI;
    endcase

    miso_d = miso_oe_d & shift_out_d[DATA_BITS-1];
  end

  always_ff @(posedge init_clk) begin
    if (init_rst) begin
      state_q        <= WAIT_HI;
      bit_cnt_q      <= '0;
      shift_in_q     <= '0;
      shift_out_q    <= '0;
      miso_q         <= 1'b0;
      miso_oe_q      <= 1'b0;
      reg_wr_valid_q <= 1'b0;
      reg_wr_addr_q  <= '0;
      reg_wr_data_q  <= '0;
      soft_rst_q     <= 1'b0;
      for (int k = 0; k < NUM_REGS; k++) begin
        bank_q[k] <= RESET_VALUES[k*DATA_BITS +: DATA_BITS];
      end
`ifdef ADC_SPI_RESP_ERRCNT_EN
      err_cnt_q      <= '0;
`endif
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_in_q     <= shift_in_d;
      shift_out_q    <= shift_out_d;
      miso_q         <= miso_d;
      miso_oe_q      <= miso_oe_d;
      reg_wr_valid_q <= reg_wr_valid_d;
      reg_wr_addr_q  <= reg_wr_addr_d;
      reg_wr_data_q  <= reg_wr_data_d;
      soft_rst_q     <= soft_rst_d;
      bank_q         <= bank_d;
`ifdef ADC_SPI_RESP_ERRCNT_EN
      err_cnt_q      <= err_cnt_d;
`endif
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_REGS; k++) begin
      reg_bank[k*DATA_BITS +: DATA_BITS] = bank_q[k];
    end
  end

  assign adc_spi_miso    = miso_q;
  assign adc_spi_miso_oe = miso_oe_q;
  assign reg_wr_valid    = reg_wr_valid_q;
  assign reg_wr_addr     = reg_wr_addr_q;
  assign reg_wr_data     = reg_wr_data_q;
`ifdef ADC_SPI_RESP_ERRCNT_EN
  assign frame_err_cnt   = err_cnt_q;
`endif

endmodule
